// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared state type and default sizing for the tick scheduler
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIV_DEFAULT    = 25000000;
  localparam int NUM_CH_DEFAULT = 4;
  localparam int CH_W_DEFAULT   = 2;
  localparam int PER_W_DEFAULT  = 8;
  localparam int PRE_W_DEFAULT  = 25;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one periodic/one-shot channel counting base ticks
module tick_channel #(
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PER_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             cfg_en,
  input  logic             tick_pulse,
  output logic             ch_tick,
  output logic             ch_active
);

  logic [PER_W-1:0] period;
  logic [PER_W-1:0] cnt;
  logic             oneshot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      cnt       <= '0;
      oneshot   <= 1'b0;
      ch_tick   <= 1'b0;
      ch_active <= 1'b0;
    end else begin
      ch_tick <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (cfg_we) begin
        period    <= cfg_period;
        oneshot   <= cfg_oneshot;
        cnt       <= '0;
        ch_active <= cfg_en && (cfg_period != '0);
      end else if (tick_pulse && ch_active) begin
        // cnt runs 0..period-1, firing on the last base tick of each period
        if (cnt == period - PER_W'(1)) begin
          cnt     <= '0;
          ch_tick <= 1'b1;
          if (oneshot) ch_active <= 1'b0;
        end else begin
          cnt <= cnt + PER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - prescaler, run/pause FSM, square wave and channel bank
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int CH_W   = CH_W_DEFAULT,
  parameter int PER_W  = PER_W_DEFAULT,
  parameter int DIV    = DIV_DEFAULT,
  parameter int PRE_W  = PRE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic              cfg_en,
  output logic              base_tick,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_active,
  output logic              sq_out
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_pulse;
  logic             cfg_acc;

  assign tick_pulse = (state == RUN) && (pre_cnt == PRE_LAST);
  // Holding off config during tick_pulse keeps channel writes and counts disjoint
  assign cfg_ready  = ~clr & ~tick_pulse;
  assign cfg_acc    = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      base_tick <= 1'b0;
      sq_out    <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      base_tick <= 1'b0;
      sq_out    <= 1'b0;
    end else begin
      base_tick <= tick_pulse;
      if (tick_pulse) sq_out <= ~sq_out;
      case (state)
        IDLE: begin
          pre_cnt <= '0;
          if (run) state <= RUN;
        end
        RUN: begin
          pre_cnt <= tick_pulse ? '0 : pre_cnt + PRE_W'(1);
          if (!run) state <= PAUSE;
        end
        PAUSE: begin
          if (run) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(i);

    tick_channel #(
      .PER_W(PER_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .cfg_we     (cfg_acc && (cfg_ch == CH_ID)),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .cfg_en     (cfg_en),
      .tick_pulse (tick_pulse),
      .ch_tick    (ch_tick[i]),
      .ch_active  (ch_active[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed vector bench for tick_scheduler
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int PER_W  = 8;
  localparam int DIV    = 4;
  localparam int PRE_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              clr;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [PER_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic              cfg_en;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_active;
  logic              sq_out;

  tick_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PER_W(PER_W), .DIV(DIV), .PRE_W(PRE_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clr        (clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .cfg_en     (cfg_en),
    .base_tick  (base_tick),
    .ch_tick    (ch_tick),
    .ch_active  (ch_active),
    .sq_out     (sq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       clr;
    logic       valid;
    logic [2:0] ch;
    logic [7:0] per;
    logic       os;
    logic       en;
    logic       rdy;
    logic       base;
    logic [3:0] tick;
    logic [3:0] act;
    logic       sq;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic v, input logic [2:0] ch,
                              input logic [7:0] per, input logic os, input logic en,
                              input logic rdy, input logic base, input logic [3:0] tick,
                              input logic [3:0] act, input logic sq);
    vec_t x;
    x.run = r; x.clr = c; x.valid = v; x.ch = ch; x.per = per; x.os = os; x.en = en;
    x.rdy = rdy; x.base = base; x.tick = tick; x.act = act; x.sq = sq;
    return x;
  endfunction

  // Drive one row, check cfg_ready before the edge and registered outputs after it
  task automatic apply(input vec_t v, input string tag, input int idx);
    run = v.run; clr = v.clr; cfg_valid = v.valid; cfg_ch = v.ch;
    cfg_period = v.per; cfg_oneshot = v.os; cfg_en = v.en;
    #1;
    chk($sformatf("%s[%0d] cfg_ready", tag, idx), 32'(cfg_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d] base_tick", tag, idx), 32'(base_tick), 32'(v.base));
    chk($sformatf("%s[%0d] ch_tick", tag, idx), 32'(ch_tick), 32'(v.tick));
    chk($sformatf("%s[%0d] ch_active", tag, idx), 32'(ch_active), 32'(v.act));
    chk($sformatf("%s[%0d] sq_out", tag, idx), 32'(sq_out), 32'(v.sq));
  endtask

  initial begin
    logic b, sq, rn;
    logic [3:0] tk;

    // Configure in IDLE: ch0 period 3 periodic, ch1 period 2 one-shot
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 3'd1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0011, 1'b0));
    // Row r below is the r-th clock edge after run is raised
    for (int r = 0; r < 26; r++) begin
      b  = (r > 0) && (r % 4 == 0);
      sq = ((r / 4) % 2) == 1;
      tk = (r == 12 || r == 24) ? 4'b0001 : ((r == 8) ? 4'b0010 : 4'b0000);
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, !b, b, tk,
                        (r >= 8) ? 4'b0001 : 4'b0011, sq));
    end
    // run low for 10 edges: tick due at 28 slips to 38
    for (int r = 26; r < 50; r++) begin
      rn = !(r >= 27 && r <= 36);
      b  = (r >= 38) && ((r - 38) % 4 == 0);
      sq = (r >= 38) && (((r - 38) / 4) % 2 == 0);
      tk = (r == 46) ? 4'b0001 : 4'b0000;
      vecs.push_back(mk(rn, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, !b, b, tk, 4'b0001, sq));
    end
    // cfg_valid held across a tick_pulse: refused at 50, accepted at 51
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd2, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd2, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0101, 1'b0));
    for (int r = 52; r < 59; r++) begin
      b  = (r == 54 || r == 58);
      sq = (r >= 54 && r < 58);
      tk = (r == 54) ? 4'b0100 : ((r == 58) ? 4'b0101 : 4'b0000);
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, !b, b, tk, 4'b0101, sq));
    end
    // Out-of-range channel is swallowed; period 0 disarms ch2
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd5, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0101, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd2, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1));
    // clr mid-count with run high: sq_out cleared, ch0 count restarts
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0));
    for (int r = 64; r < 77; r++) begin
      b  = (r >= 68) && (r % 4 == 0);
      sq = (r >= 68 && r < 72) || (r >= 76);
      tk = (r == 76) ? 4'b0001 : 4'b0000;
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, !b, b, tk, 4'b0001, sq));
    end
    // After a mid-run reset everything behaves as from power-up
    for (int p = 0; p < 9; p++) begin
      b  = (p > 0) && (p % 4 == 0);
      sq = (p >= 4 && p < 8);
      post.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, !b, b, 4'b0000, 4'b0000, sq));
    end

    rst_n = 1'b0; run = 1'b0; clr = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_oneshot = 1'b0; cfg_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset base_tick", 32'(base_tick), 32'd0);
    chk("reset ch_tick", 32'(ch_tick), 32'd0);
    chk("reset ch_active", 32'(ch_active), 32'd0);
    chk("reset sq_out", 32'(sq_out), 32'd0);
    chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "main", i);

    // Outputs are non-zero here; reset must clear them without a clock edge
    #1;
    chk("pre-reset ch_active", 32'(ch_active), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async reset base_tick", 32'(base_tick), 32'd0);
    chk("async reset ch_tick", 32'(ch_tick), 32'd0);
    chk("async reset ch_active", 32'(ch_active), 32'd0);
    chk("async reset sq_out", 32'(sq_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < post.size(); i++) apply(post[i], "post", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
